// File: rtl/apb_slave_mem_if.sv
// APB3 completer bus bundle: select/enable/write/address/data
// from the initiator, ready/read data/error back from the completer.
interface apb_slave_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_slave_mem.sv
// APB3 completer with a DEPTH x DATA_W register file, error response
// for unmapped addresses, abort and protocol-violation handling.
// Ports: PCLK, PRESET (async, active high), bus (slave modport:
// PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PREADY/PRDATA/PSLVERR out).
// Optional: define APB_SLV_WAIT_EN to insert WAIT_STATES wait cycles.
module apb_slave_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 2
) (
  input logic            PCLK,
  input logic            PRESET,
  apb_slave_mem_if.slave bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  if (WAIT_STATES < 0 || DEPTH < 1) begin : g_bad_cfg
    $error("apb_slave_mem: invalid WAIT_STATES or DEPTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR
  } state_t;

  state_t            state;
  logic [IW-1:0]     addr_q;
  logic              wr_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic setup;
  logic enable;
  logic load;
  logic in_range;
  logic wait_done;

  assign setup    = bus.PSEL & ~bus.PENABLE;
  assign enable   = bus.PSEL & bus.PENABLE;
  assign in_range = {1'b0, bus.PADDR} < DEPTH_C;
  // a setup seen while in ACCESS restarts the transfer
  assign load     = setup & (state != ERR);

`ifdef APB_SLV_WAIT_EN
  localparam int CW = $clog2(WAIT_STATES + 2);
  logic [CW-1:0] cnt;
  assign wait_done = (cnt == '0);
`else
  assign wait_done = 1'b1;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef APB_SLV_WAIT_EN
      cnt     <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (load) begin
        addr_q  <= bus.PADDR[IW-1:0];
        wr_q    <= bus.PWRITE;
        err_q   <= ~in_range;
        wdata_q <= bus.PWDATA;
`ifdef APB_SLV_WAIT_EN
        cnt     <= CW'(WAIT_STATES);
`endif
        if (!bus.PWRITE) begin
          rdata_q <= in_range ? mem[bus.PADDR[IW-1:0]]
                              : '0;
        end
      end

      unique case (state)
        IDLE: begin
          if (setup) begin
            state <= ACCESS;
          end else if (enable) begin
            state <= ERR;
          end
        end
        ACCESS: begin
          if (!bus.PSEL) begin
            state <= IDLE;
          end else if (enable) begin
            if (wait_done) begin
              if (wr_q && !err_q) begin
                mem[addr_q] <= wdata_q;
              end
              state <= IDLE;
            end
`ifdef APB_SLV_WAIT_EN
            else begin
              cnt <= cnt - CW'(1);
            end
`endif
          end
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.PREADY  = (state == ERR)
                     | ((state == ACCESS) & wait_done);
  assign bus.PSLVERR = (state == ERR)
                     | ((state == ACCESS) & wait_done & err_q);
  assign bus.PRDATA  = rdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed + random bench for apb_slave_mem against an array model.
// Each comparison is an immediate assertion that counts failures.
module tb_apb_slave_mem;

`ifdef APB_SLV_WAIT_EN
  localparam int WS = 2;
`else
  localparam int WS = 0;
`endif
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] ref_mem [DEPTH];

  apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_slave_mem #(
    .ADDR_W(8),
    .DATA_W(8),
    .DEPTH(DEPTH),
    .WAIT_STATES(2)
  ) dut (
    .PCLK(clk),
    .PRESET(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  // one complete transfer; starts right away so consecutive calls are
  // back-to-back with no idle cycle between them
  task automatic xfer(input logic wr,
                      input logic [7:0] a,
                      input logic [7:0] d);
    logic       exp_err;
    logic [7:0] exp_rd;
    int         cyc;
    bit         done;
    exp_err = (a >= 8'(DEPTH));
    exp_rd  = exp_err ? 8'h00 : ref_mem[a[3:0]];
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = a;
    bus.PWDATA  = d;
    @(posedge clk);
    #1;
    bus.PENABLE = 1'b1;
    bus.PADDR   = ~a;
    bus.PWDATA  = ~d;
    cyc  = 1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      cyc++;
      if (bus.PREADY === 1'b1) begin
        done = 1'b1;
        chk(wr ? "wr_slverr" : "rd_slverr",
            32'(bus.PSLVERR), 32'(exp_err));
        if (!wr) chk("rd_data", 32'(bus.PRDATA), 32'(exp_rd));
      end else begin
        chk("wait_slverr", 32'(bus.PSLVERR), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    chk("xfer_cycles", 32'(cyc), 32'(2 + WS));
    if (wr && !exp_err) ref_mem[a[3:0]] = d;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic readback_all();
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, 8'(i), 8'h00);
  endtask

  initial begin
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    checks = 0;
    errors = 0;
    clear_model();
    rst         = 1'b1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 8'h00;
    bus.PWDATA  = 8'h00;

    // reset and idle
    #10;
    chk("rst_pready", 32'(bus.PREADY), 32'd0);
    #13;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("idle_pready", 32'(bus.PREADY), 32'd0);
      chk("idle_pslverr", 32'(bus.PSLVERR), 32'd0);
      chk("idle_prdata", 32'(bus.PRDATA), 32'd0);
      @(posedge clk);
      #1;
    end
    readback_all();

    // basic write/read
    idle(1);
    xfer(1'b1, 8'd3, 8'hA5);
    xfer(1'b0, 8'd3, 8'h00);
    idle(1);
    chk("hold_prdata", 32'(bus.PRDATA), 32'hA5);
    chk("hold_pready", 32'(bus.PREADY), 32'd0);
    xfer(1'b1, 8'd4, 8'h11);
    chk("hold_after_wr", 32'(bus.PRDATA), 32'hA5);

    // wait-state write and readback
    xfer(1'b1, 8'd7, 8'h3C);
    xfer(1'b0, 8'd7, 8'h00);

    // unmapped address
    idle(2);
    xfer(1'b1, 8'd20, 8'h55);
    xfer(1'b0, 8'd20, 8'h00);
    readback_all();

    // abort during access
    idle(1);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 8'd5;
    bus.PWDATA  = 8'hFF;
    @(posedge clk);
    #1;
    bus.PENABLE = 1'b1;
    if (WS > 0) begin
      @(posedge clk);
      #1;
    end
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_pready", 32'(bus.PREADY), 32'd0);
    chk("abort_pslverr", 32'(bus.PSLVERR), 32'd0);
    xfer(1'b0, 8'd5, 8'h00);

    // asynchronous reset in the middle of an unmapped write
    idle(1);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 8'd20;
    bus.PWDATA  = 8'h77;
    @(posedge clk);
    #1;
    bus.PENABLE = 1'b1;
    chk("pre_rst_pready", 32'(bus.PREADY), 32'(WS == 0));
    chk("pre_rst_pslverr", 32'(bus.PSLVERR), 32'(WS == 0));
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_pready", 32'(bus.PREADY), 32'd0);
    chk("mid_rst_pslverr", 32'(bus.PSLVERR), 32'd0);
    chk("mid_rst_prdata", 32'(bus.PRDATA), 32'd0);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    #1;
    rst = 1'b0;
    clear_model();
    idle(1);
    xfer(1'b0, 8'd3, 8'h00);
    xfer(1'b0, 8'd7, 8'h00);

    // protocol violation: enable without setup
    idle(1);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 8'd2;
    bus.PWDATA  = 8'hEE;
    @(posedge clk);
    #1;
    chk("viol_pready", 32'(bus.PREADY), 32'd1);
    chk("viol_pslverr", 32'(bus.PSLVERR), 32'd1);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge clk);
    #1;
    chk("viol_end_pready", 32'(bus.PREADY), 32'd0);
    chk("viol_end_pslverr", 32'(bus.PSLVERR), 32'd0);
    xfer(1'b0, 8'd2, 8'h00);

    // back-to-back writes then reads
    idle(1);
    for (int i = 0; i < 8; i++) xfer(1'b1, 8'(i), 8'(2 * i));
    for (int i = 0; i < 8; i++) xfer(1'b0, 8'(i), 8'h00);

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 23));
      d  = 8'($urandom);
      xfer(wr, a, d);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(1);
    readback_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB3 completer (slave) holding a small byte-wide register file. It answers the initiator/bridge side of the team's APB subsystem. Each instance sits behind one PSEL line and sees the local address bits only, with the slave-select MSB already decoded by the bridge. It supports programmable wait states, out-of-range error response and abort handling.

Parameters:
ADDR_W, 8, width of local PADDR
DATA_W, 8, width of PWDATA/PRDATA
DEPTH, 16, number of implemented locations; addresses >= DEPTH are unmapped
WAIT_STATES, 2, PREADY-low cycles in each access phase (used only when APB_SLV_WAIT_EN is defined)

Ports:
PCLK  input  1  APB clock; all logic on the rising edge
PRESET  input  1  asynchronous, active-high reset
PSEL  input  1  slave select from bridge
PENABLE  input  1  access-phase strobe
PWRITE  input  1  1 = write, 0 = read
PADDR  input  ADDR_W  local byte address
PWDATA  input  DATA_W  write data
PREADY  output  1  transfer-complete indication
PRDATA  output  DATA_W  read data, valid when PREADY=1 and PWRITE=0
PSLVERR  output  1  error response, valid only while PREADY=1

Behaviour:
- Reset (PRESET=1, asynchronous): state=IDLE, wait counter=0, PREADY=0, PSLVERR=0, PRDATA=0, all DEPTH locations cleared to 0.
- States:
  - IDLE: wait for a setup phase.
  - ACCESS: access phase in progress; the wait counter runs down here.
  - ERR: protocol-violation response.
- IDLE to ACCESS:
  - Trigger: rising edge with PSEL=1 and PENABLE=0 (setup phase).
  - Capture PADDR, PWRITE and PWDATA into internal registers.
  - Load counter = WAIT_STATES (0 when the macro is undefined).
  - Set err_flag = (PADDR >= DEPTH).
  - For a read with err_flag=0, load PRDATA = mem[PADDR]. For a read with err_flag=1, load PRDATA = 0.
- In ACCESS:
  - PREADY = (counter==0), decoded from registered state.
  - PSLVERR = PREADY & err_flag.
  - Each edge with PSEL=1, PENABLE=1 and counter>0 decrements the counter.
- Completion edge (ACCESS, PSEL=1, PENABLE=1, PREADY=1):
  - Write with no error: mem[captured addr] <= captured PWDATA.
  - Write with error: memory unchanged.
  - Next state is IDLE. If PSEL=1 and PENABLE=0 on that same cycle, the edge is treated as a fresh setup and the next state is ACCESS (back-to-back transfers).
- Minimum transfer length: 2 cycles (setup + access) plus WAIT_STATES.
- PRDATA holds its value after completion until the next read setup.
- Address/data changes during ACCESS are ignored; the captured values are used.
- Abort: PSEL dropping to 0 while in ACCESS returns to IDLE on the next edge with no memory write. PREADY and PSLVERR go to 0.
- Protocol violation: PSEL=1 and PENABLE=1 seen in IDLE (no prior setup) moves to ERR. ERR drives PREADY=1 and PSLVERR=1 for exactly one cycle, performs no memory access, then returns to IDLE.
- Read-after-write to the same address in consecutive transfers returns the newly written data.
- PREADY, PSLVERR and PRDATA are 0 in IDLE, except that PRDATA holds its last value as stated above.

Optional Feature:
- Macro: APB_SLV_WAIT_EN.
- Defined: the ACCESS phase inserts WAIT_STATES cycles with PREADY=0 before completion, and the counter logic is present.
- Undefined: the counter is removed, PREADY=1 on the first access cycle (zero-wait), and WAIT_STATES is ignored. All other behaviour is identical.

Test Plan:
1. Reset then idle: PRESET pulse, PSEL=0 for 5 cycles -> PREADY=0, PSLVERR=0, PRDATA=0 throughout; reading addr 0..15 afterwards returns 8'h00.
2. Write/read, zero-wait (macro off):
   - Write addr 3 = 8'hA5, then read addr 3 -> each transfer completes in exactly 2 cycles.
   - PRDATA=8'hA5 with PREADY=1 and PSLVERR=0.
3. Wait states (macro on, WAIT_STATES=2): write addr 7 = 8'h3C -> PREADY low for 2 access cycles and high on the 3rd; mem[7]=8'h3C only after the completion edge; readback = 8'h3C.
4. Unmapped address: write 8'h55 to addr 20 (DEPTH=16), then read addr 20 -> both complete with PSLVERR=1 and PREADY=1; read PRDATA=0; addrs 0..15 are unchanged.
5. Abort and reset mid-operation:
   - Abort case: setup write addr 5 = 8'hFF, then drop PSEL during the wait phase -> mem[5] stays 0.
   - Reset case: assert PRESET mid-ACCESS -> PREADY=0 and state IDLE immediately (asynchronous).
6. Protocol violation and back-to-back:
   - Violation: PSEL=1 and PENABLE=1 without a setup phase -> one-cycle PREADY=1 with PSLVERR=1, and no write.
   - Back-to-back: writes to addrs 0..7 with data 2*i and no idle cycles, followed by reads -> data 0,2,4,...,14 returned in order.
